// File: rtl/pronoc_pkg.sv
// Shared types, sizing constants and the class-to-VC mask helper for the
// output-VC allocation controller.
package pronoc_pkg;

    localparam int V        = 4;
    localparam int C        = 2;
    localparam int CW       = (C > 1) ? $clog2(C) : 1;
    localparam int N        = 4;
    localparam int B        = 4;
    localparam int CREDIT_W = $clog2(B + 1);

    typedef logic [CREDIT_W-1:0] ovc_credit_t;

    localparam ovc_credit_t CREDIT_MAX = ovc_credit_t'(B);

    // VCs usable by class cls; out-of-range classes get no VC at all.
    function automatic logic [V-1:0] class_mask(input logic [C*V-1:0] setting,
                                                input logic [CW-1:0]  cls);
        logic [V-1:0] m;
        m = '0;
        if (C <= 1) begin
            m = '1;
        end else begin
            for (int c = 0; c < C; c++) begin
                if (int'(cls) == c) m = setting[c*V +: V];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ovc_alloc_ctrl_if.sv
// Request/grant and flit/credit signalling between the input-VC side and the
// output-VC allocation controller of one router output port.
interface ovc_alloc_ctrl_if;
    import pronoc_pkg::*;

    logic [N-1:0]    req;
    logic [N*CW-1:0] req_class;
    logic [N-1:0]    grant;
    logic [N*V-1:0]  grant_ovc;
    logic [V-1:0]    flit_sent;
    logic [V-1:0]    tail_sent;
    logic [V-1:0]    credit_in;
    logic [V-1:0]    ovc_free;
    logic [V-1:0]    credit_avail;
    logic            err;

    modport master (
        output req, req_class, flit_sent, tail_sent, credit_in,
        input  grant, grant_ovc, ovc_free, credit_avail, err
    );

    modport slave (
        input  req, req_class, flit_sent, tail_sent, credit_in,
        output grant, grant_ovc, ovc_free, credit_avail, err
    );

endinterface

// File: rtl/ovc_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick starting at the registered
// pointer; the pointer moves past the winner only when en is high.
module ovc_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next_ptr;
    logic          w_found;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave a value unassigned and infer a latch.
    always_comb begin
        o_grant    = '0;
        w_found    = 1'b0;
        w_next_ptr = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            automatic int idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && i_req[idx]) begin
                w_found      = 1'b1;
                o_grant[idx] = 1'b1;
                w_next_ptr   = PW'((idx + 1) % NREQ);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (en && w_found) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/ovc_alloc_ctrl.sv
// Output-VC allocation for one output port: class-filtered round-robin grant,
// VC ownership until tail, and per-VC downstream credit counters.
module ovc_alloc_ctrl
    import pronoc_pkg::*;
#(
    parameter logic [C*V-1:0] CLASS_SETTING = '1
) (
    input logic             clk,
    input logic             reset,
    ovc_alloc_ctrl_if.slave bus
);

    logic [N-1:0]   r_grant;
    logic [N*V-1:0] r_grant_ovc;
    logic [V-1:0]   r_ovc_free;
    ovc_credit_t    r_credit [V];
    logic           r_err;

    logic [V-1:0]   w_cls_mask [N];
    logic [N-1:0]   w_elig;
    logic [N-1:0]   w_win;
    logic [V-1:0]   w_win_mask;
    logic [V-1:0]   w_sel_vc;
    logic [N*V-1:0] w_grant_ovc_nxt;
    logic [V-1:0]   w_err_cred;
    logic [V-1:0]   w_err_tail;
    logic [V-1:0]   w_credit_avail;

    // Eligibility looks only at the registered free vector, so a VC released
    // at an edge cannot be handed out at that same edge.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N; i++) begin
            w_cls_mask[i] = class_mask(CLASS_SETTING, bus.req_class[i*CW +: CW]);
            w_elig[i]     = bus.req[i] & ~r_grant[i] & (|(w_cls_mask[i] & r_ovc_free));
        end
    end

    ovc_rr_arbiter #(
        .NREQ (N)
    ) u_rr_arbiter (
        .clk     (clk),
        .reset   (reset),
        .en      (|w_elig),
        .i_req   (w_elig),
        .o_grant (w_win)
    );

    // x & -x isolates the lowest set bit: the lowest-index usable free VC.
    always_comb begin
        w_win_mask      = '0;
        w_grant_ovc_nxt = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win[i]) w_win_mask = w_cls_mask[i] & r_ovc_free;
        end
        w_sel_vc = w_win_mask & (~w_win_mask + V'(1));
        for (int i = 0; i < N; i++) begin
            if (w_win[i]) w_grant_ovc_nxt[i*V +: V] = w_sel_vc;
        end
    end

    always_comb begin
        w_err_cred     = '0;
        w_credit_avail = '0;
        w_err_tail     = bus.tail_sent & r_ovc_free;
        for (int v = 0; v < V; v++) begin
            w_err_cred[v] = (bus.flit_sent[v] & ~bus.credit_in[v] & (r_credit[v] == '0)) |
                            (bus.credit_in[v] & ~bus.flit_sent[v] & (r_credit[v] == CREDIT_MAX));
            w_credit_avail[v] = (r_credit[v] != '0);
        end
    end

    // NOTE: the credit counters are architectural state with a defined start
    // value of B, so every element of the array is reset, unlike a data RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant     <= '0;
            r_grant_ovc <= '0;
            r_ovc_free  <= '1;
            r_err       <= 1'b0;
            for (int v = 0; v < V; v++) r_credit[v] <= CREDIT_MAX;
        end else begin
            r_grant     <= w_win;
            r_grant_ovc <= w_grant_ovc_nxt;
            r_ovc_free  <= (r_ovc_free & ~w_sel_vc) | bus.tail_sent;
            r_err       <= r_err | (|w_err_cred) | (|w_err_tail);
            for (int v = 0; v < V; v++) begin
                case ({bus.flit_sent[v], bus.credit_in[v]})
                    2'b10: if (r_credit[v] != '0)         r_credit[v] <= r_credit[v] - ovc_credit_t'(1);
                    2'b01: if (r_credit[v] != CREDIT_MAX) r_credit[v] <= r_credit[v] + ovc_credit_t'(1);
                    default: ;
                endcase
            end
        end
    end

    assign bus.grant        = r_grant;
    assign bus.grant_ovc    = r_grant_ovc;
    assign bus.ovc_free     = r_ovc_free;
    assign bus.credit_avail = w_credit_avail;
    assign bus.err          = r_err;

endmodule
